load_store_unit: RTL
====================

# load_store_unit

Multicycle data-memory access unit between the datapath and the 64-bit data memory. Takes an address (ALU result), store data (register B) and RISC-V `funct3`, and performs naturally aligned loads and stores of byte, half, word and doubleword. Partial stores use read-modify-write on the enclosing doubleword. Loads return a sign- or zero-extended 64-bit result for the memory-data register.

## Interface
- `ADDR_W`, 64, address width; low 3 bits select the byte lane.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  start access; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Stores: 000 sb, 001 sh, 010 sw, 011 sd.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  64  store data; low bytes used.
- `rdata`  out  64  extended load result; holds until the next successful load.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  access in progress.
- `fault`  out  1  pulses together with `done` on a misaligned address or an illegal `funct3`.
- `mem_addr`  out  ADDR_W  doubleword address (`addr` with bits [2:0] = 0).
- `mem_wdata`  out  64  write data to memory.
- `mem_wr`  out  1  memory write strobe.
- `mem_rdata`  in  64  memory read data, valid one cycle after `mem_addr`.

## Operation
- Memory is little-endian. Byte k of a doubleword is bits [8k+7:8k]. Offset `off = addr[2:0]`.
- Alignment rules:
  - Halfword requires `off[0]=0`.
  - Word requires `off[1:0]=0`.
  - Doubleword requires `off=0`.
- Illegal `funct3`: 111 for any access, and `funct3[2]=1` for a store.
- FSM states: IDLE, RD, CAP, WR, FIN, ERR.
- **IDLE**, on `req`: latch `we`, `funct3`, `addr` and `wdata`, and load `mem_addr`. Next state:
  - fault condition → ERR;
  - sd → WR, with `mem_wdata` = `wdata`;
  - otherwise → RD.
- **RD**: address presented, `mem_wr`=0. Next state CAP.
- **CAP**: `mem_rdata` is valid.
  - Load: `rdata` ← selected lanes, sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu/ld). Next state FIN.
  - Partial store: `mem_wdata` ← `mem_rdata` with lanes off..off+size-1 replaced by the low bytes of `wdata`. Next state WR.
- **WR**: `mem_wr`=1 for exactly this cycle. Next state FIN.
- **FIN**: `done`=1. Next state IDLE.
- **ERR**: `done`=1 and `fault`=1. No memory read or write; `rdata` unchanged. Next state IDLE.
- `busy`=1 in RD, CAP and WR; 0 otherwise.
- `req` outside IDLE, including in FIN and ERR, is ignored. It is not queued.

## Timing
- Count from the req-accept edge as cycle 0.
- Load: `done` in cycle 3. `rdata` is valid from cycle 3.
- Partial store: `mem_wr` in cycle 3, `done` in cycle 4.
- sd: `mem_wr` in cycle 1, `done` in cycle 2.
- Fault: `done` and `fault` in cycle 1.
- A back-to-back `req` is accepted no earlier than the cycle after `done`, i.e. in IDLE.
- Reset values (all outputs 0): `rdata`=0, `done`=0, `busy`=0, `fault`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0. State is IDLE.
- Reset mid-operation: state goes to IDLE and `mem_wr` drops immediately (asynchronously). No partial write is issued after reset deasserts.
- `mem_wr`, `done` and `fault` are registered state decodes, glitch-free.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`);
  - a function returning access size in bytes.
- Sub-module `load_extract` (combinational): doubleword, `off` and `funct3` → extended 64-bit result. It is reused by the store merge logic for lane selection.

## Test plan
- Memory[0x10] = 0x8877665544332211. lb at 0x17 → `rdata`=0xFFFFFFFFFFFFFF88, `done` in cycle 3, `mem_wr` never asserted.
- Same memory. lhu at 0x16 → 0x0000000000008877. lw at 0x14 → 0xFFFFFFFF88776655. ld at 0x10 → 0x8877665544332211.
- sb at 0x13 with `wdata`=0xAB → memory becomes 0x88776655AB332211. `mem_wr` high for exactly one cycle (cycle 3), `done` in cycle 4.
- sd at 0x10 with `wdata`=0x0123456789ABCDEF → `mem_wr` in cycle 1 with no prior read cycle, `done` in cycle 2, memory updated.
- lw at 0x12, then sw with `funct3`=110 → each gives `done`+`fault` in cycle 1, no `mem_wr`, `rdata` unchanged.
- sh at 0x10, `rst` asserted during WR → `mem_wr` falls in the same cycle, memory unchanged, all outputs 0. The next `req` is accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int ADDR_W = 64;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN, ERR} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size in bytes; funct3[1:0] encodes log2(size) for loads and stores.
   function automatic logic [3:0] access_size(input logic [2:0] f3);
      return 4'd1 << f3[1:0];
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side and memory-side signals of the load/store unit.
interface lsu_if;
   import lsu_pkg::*;

   logic              req;
   logic              we;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [63:0]       wdata;
   logic [63:0]       rdata;
   logic              done;
   logic              busy;
   logic              fault;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic              mem_wr;
   logic [63:0]       mem_rdata;

   modport slave (
      input  req, we, funct3, addr, wdata, mem_rdata,
      output rdata, done, busy, fault, mem_addr, mem_wdata, mem_wr
   );

   modport master (
      output req, we, funct3, addr, wdata, mem_rdata,
      input  rdata, done, busy, fault, mem_addr, mem_wdata, mem_wr
   );

endinterface

// File: rtl/load_extract.sv
// Picks the addressed lanes of a doubleword and sign/zero-extends them.
module load_extract
   import lsu_pkg::*;
(
   input  logic [63:0] dword,
   input  logic [2:0]  off,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] shifted;

   assign shifted = dword >> {off, 3'b000};

   // Extend the low bytes of the shifted doubleword according to funct3.
   always_comb begin
      result = '0;
      case (funct3)
         F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
         F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
         F3_D:    result = shifted;
         F3_BU:   result = {56'd0, shifted[7:0]};
         F3_HU:   result = {48'd0, shifted[15:0]};
         F3_WU:   result = {32'd0, shifted[31:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle aligned load/store unit with read-modify-write for partial stores.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);

   localparam logic [63:0] ALL_ONES = '1;

   state_t      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [2:0]  off_q;
   logic [63:0] wdata_q;
   logic [3:0]  size;
   logic        misalign, illegal, bad;
   logic [63:0] load_val;
   logic [2:0]  mask_f3;
   logic [63:0] mask_low, mask, merged;

   assign size     = access_size(bus.funct3);
   assign misalign = (({1'b0, bus.addr[2:0]} & (size - 4'd1)) != 4'd0);
   assign illegal  = (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
   assign bad      = misalign || illegal;

   load_extract u_load (
      .dword  (bus.mem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .result (load_val)
   );

   // Zero-extending extract of an all-ones word yields a low-aligned byte-lane mask.
   assign mask_f3 = (f3_q == F3_D) ? F3_D : {1'b1, f3_q[1:0]};

   load_extract u_mask (
      .dword  (ALL_ONES),
      .off    (3'd0),
      .funct3 (mask_f3),
      .result (mask_low)
   );

   assign mask   = mask_low << {off_q, 3'b000};
   assign merged = (bus.mem_rdata & ~mask) | ((wdata_q << {off_q, 3'b000}) & mask);
   assign bus.busy = (state == RD) || (state == CAP) || (state == WR);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; req is only looked at in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.req) begin
            if (bad)                                state_nx = ERR;
            else if (bus.we && bus.funct3 == F3_D)  state_nx = WR;
            else                                    state_nx = RD;
         end
         RD:      state_nx = CAP;
         CAP:     state_nx = we_q ? WR : FIN;
         WR:      state_nx = FIN;
         FIN:     state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, load capture, store merge and registered strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q          <= 1'b0;
         f3_q          <= '0;
         off_q         <= '0;
         wdata_q       <= '0;
         bus.rdata     <= '0;
         bus.done      <= 1'b0;
         bus.fault     <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wr    <= 1'b0;
      end else begin
         bus.mem_wr <= (state_nx == WR);
         bus.done   <= (state_nx == FIN) || (state_nx == ERR);
         bus.fault  <= (state_nx == ERR);
         case (state)
            IDLE: if (bus.req) begin
               we_q         <= bus.we;
               f3_q         <= bus.funct3;
               off_q        <= bus.addr[2:0];
               wdata_q      <= bus.wdata;
               bus.mem_addr <= {bus.addr[ADDR_W-1:3], 3'b000};
               if (state_nx == WR) bus.mem_wdata <= bus.wdata;
            end
            CAP: begin
               if (we_q) bus.mem_wdata <= merged;
               else      bus.rdata     <= load_val;
            end
            default: ;
         endcase
      end
   end

endmodule
